// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one external combinational ALU (AND/OR/ADD/SUB/MUL/SLT, zero flag)
//   between two requesters. Round-robin grant in IDLE, operands registered at
//   accept and held on alu_a/alu_b/alu_op for the whole operation, extra
//   settle cycles for MUL, result returned on a valid/ready channel tagged
//   with the requester id. One operation in flight at a time.
//
//   Optional build macro: ALU_ARB_ILLEGAL_OP_EN
//     Adds rsp_err; opcodes 011/111 bypass the ALU and respond one cycle
//     after accept with result 0, zero 1, err 1.
//
// Ports
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   reqN_valid / reqN_ready      request handshake for requester N (0/1)
//   reqN_a, reqN_b, reqN_op      requester N operands and opcode
//   alu_a, alu_b, alu_op         registered operands/opcode to the shared ALU
//   alu_out, alu_zero            ALU result and zero flag
//   rsp_valid / rsp_ready        response handshake
//   rsp_id, rsp_result, rsp_zero response tag, captured result, captured zero
//   rsp_err                      illegal-opcode flag (macro builds only)
//   busy                         an operation is in flight
module alu_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
`ifdef ALU_ARB_ILLEGAL_OP_EN
  output logic             rsp_err,
`endif
  output logic             busy
);

  localparam logic [2:0]  OP_MUL = 3'b101;
  localparam int unsigned CW     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, MWAIT, RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_id;
  logic             r_prio;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic             r_err;
  logic             w_ill;
  logic             w_ill_load;
`endif

  logic             w_any;
  logic             w_gnt_id;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [2:0]       w_sel_op;
  logic             w_accept;
  logic             w_capture;
  logic             w_cnt_load;
  logic             w_cnt_inc;

  // Grant: a lone requester wins; on contention the prio bit picks.
  assign w_any    = req0_valid | req1_valid;
  assign w_gnt_id = (req0_valid & req1_valid) ? r_prio : req1_valid;
  assign w_sel_a  = w_gnt_id ? req1_a  : req0_a;
  assign w_sel_b  = w_gnt_id ? req1_b  : req0_b;
  assign w_sel_op = w_gnt_id ? req1_op : req0_op;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  assign w_ill    = (w_sel_op[1:0] == 2'b11);
  assign rsp_err  = r_err;
`endif

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_op     = r_op;
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_inc   = 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    w_ill_load  = 1'b0;
`endif
    rsp_valid   = (r_state == RESP);
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        // Ready is masked during reset so a request never sees a false accept.
        if (!rst && w_any) begin
          req0_ready  = ~w_gnt_id;
          req1_ready  = w_gnt_id;
          w_accept    = 1'b1;
`ifdef ALU_ARB_ILLEGAL_OP_EN
          if (w_ill) begin
            w_ill_load  = 1'b1;
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = EXEC;
          end
`else
          w_state_nxt = EXEC;
`endif
        end
      end
      EXEC: begin
        if (r_op != OP_MUL || MUL_LAT == 1) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_cnt_load  = 1'b1;
          w_state_nxt = MWAIT;
        end
      end
      MWAIT: begin
        if (r_cnt == CW'(MUL_LAT - 1)) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      default: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_id     <= 1'b0;
      r_prio   <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
      r_err    <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_a    <= w_sel_a;
        r_b    <= w_sel_b;
        r_op   <= w_sel_op;
        r_id   <= w_gnt_id;
        r_prio <= ~w_gnt_id;
      end
      if (w_cnt_load) begin
        r_cnt <= CW'(1);
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_capture) begin
        r_result <= alu_out;
        r_zero   <= alu_zero;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        r_err    <= 1'b0;
`endif
      end
`ifdef ALU_ARB_ILLEGAL_OP_EN
      if (w_ill_load) begin
        r_result <= '0;
        r_zero   <= 1'b1;
        r_err    <= 1'b1;
      end
`endif
    end
  end

endmodule
